mash_dsm_mc: RTL and testbench
==============================

// Module: mash_dsm_mc
// PURPOSE
//  Multi-channel, runtime-order-selectable MASH delta-sigma modulator (1, 1-1, 1-1-1). Converts N_CH
//  signed WIDTH-bit samples (e.g. NCO I/Q) to signed OUT_BW-bit multi-level codes, one per accepted sample.
//  Sits between NCO/tx datapath and per-channel 1-bit DSM/upconverter stage; generalises fixed 1-1 MASH.
// PARAMETERS
//  WIDTH       16  input sample / accumulator width (bits)
//  N_CH        2   number of independent channels (1..8)
//  MAX_ORDER   3   highest supported MASH order (1..3)
//  OUT_BW      4   output code width, signed; must be >= MAX_ORDER+1 (order 3 range -3..+4)
//  RST_ORDER   2   order active after reset (1..MAX_ORDER)
//  LFSR_SEED   23'h5A5A5A  nonzero reset seed of dither LFSR
// PORTS
//  aclk           in   1            clock
//  rst_n          in   1            async reset, active-low
//  ce             in   1            sample strobe; in_data accepted when ce=1 and busy=0
//  in_data        in   N_CH*WIDTH   signed samples, channel c at [c*WIDTH +: WIDTH]
//  dither_enable  in   1            1 = add LFSR LSB dither to last active stage
//  cfg_load       in   1            pulse: latch order_sel and flush
//  order_sel      in   2            requested order; 0 -> 1, >MAX_ORDER -> MAX_ORDER
//  busy           out  1            1 while flushing; ce ignored
//  order_cur      out  2            order currently in effect
//  out_valid      out  1            out_data holds new codes
//  out_data       out  N_CH*OUT_BW  signed MASH codes, channel c at [c*OUT_BW +: OUT_BW]
// BEHAVIOUR
//  Reset (async assert, sync-to-aclk release): all accumulators, carry regs, differentiator delays,
//   out_data=0, out_valid=0, busy=0, order_cur=RST_ORDER, LFSR=LFSR_SEED, FSM=RUN.
//  Input mapping: u = in_data ^ (1<<(WIDTH-1)) (offset binary, 0..2^WIDTH-1); mean(out) = u/2^WIDTH.
//  Stage k (1..order_cur), on accepted sample: s_k = acc_k + in_k + d_k (WIDTH+1 bits);
//   acc_k <= s_k[WIDTH-1:0]; c_k <= s_k[WIDTH]. in_1 = u, in_(k+1) = new acc_k (same-cycle chain).
//   d_k = LFSR bit c (per channel) for k = order_cur when dither_enable, else 0. Inactive stages held 0.
//  Combine (registered, uses c_k regs and their delays, delays advance only on accepted sample):
//   order1: y = c1; order2: y = c1 + c2 - c2_d; order3: y = c1 + c2 - c2_d + c3 - 2*c3_d + c3_dd.
//   y sign-extended to OUT_BW; no saturation needed given OUT_BW rule.
//  Latency: sample accepted in cycle n -> out_valid=1 with its code in cycle n+2; out_valid is 1-cycle
//   pulse per sample; no ce -> state frozen, out_valid=0, out_data holds last value.
//  LFSR: 23-bit Fibonacci x^23+x^18+1, advances once per accepted sample only.
//  FSM: RUN --cfg_load--> FLUSH (2 cycles, busy=1) --> RUN.
//   Entering FLUSH: order_cur <= clamped order_sel; acc/carry/delay regs cleared; in-flight samples
//   discarded (out_valid forced 0 during FLUSH and first cycle after); out_data cleared to 0; LFSR kept.
//   cfg_load while in FLUSH restarts 2-cycle count with new order. cfg_load and ce same cycle: cfg_load wins.
//  Accumulators wrap modulo 2^WIDTH; carries are the only overflow path.
//  Reset mid-operation: immediate return to reset values; no output until next accepted sample +2.
// TESTING
//  1. Order1, in=0 (u=0x8000), dither off, ce continuous -> out 0,1,0,1,... first valid 2 cycles after ce.
//  2. Order2/3, in=-32768 -> all codes 0; in=+32767 over 65536 samples -> |sum-65535| <= 2^(order-1).
//  3. Order3, in=0x1234, 65536 samples -> codes within -3..+4, |sum-(0x9234)| <= 4; I and Q differing
//     inputs give independent sums per channel.
//  4. ce gapped (1 of 4 cycles) -> identical code sequence to continuous ce, out_valid only n+2 after each.
//  5. cfg_load order_sel=3 mid-stream -> busy=1 for 2 cycles, out_valid=0, order_cur=3, then fresh
//     sequence matches reset-start order-3 sequence; order_sel=0 -> order_cur=1.
//  6. rst_n low mid-stream -> all outputs 0 same cycle; dither on in=0, order2 -> sum over 65536 within +-8.

Source files
------------

// File: rtl/mash_dsm_mc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mash_dsm_mc
//   Multi-channel MASH delta-sigma modulator with an order (1, 1-1 or 1-1-1)
//   that can be changed at runtime. Each channel turns a signed WIDTH-bit
//   sample into a signed OUT_BW-bit multi-level code. The mean of a channel's
//   codes equals u / 2^WIDTH, where u is the sample in offset binary.
//
// Ports
//   aclk, rst_n    clock, async active-low reset
//   ce             sample strobe; ignored while busy or while cfg_load is high
//   in_data        N_CH packed signed samples, channel c at [c*WIDTH +: WIDTH]
//   dither_enable  adds LFSR bit c to the last active stage of channel c
//   cfg_load       latch order_sel (clamped to 1..MAX_ORDER) and flush
//   order_sel      requested order
//   busy           high during the 2-cycle flush
//   order_cur      order currently in effect
//   out_valid      one-cycle pulse, 2 cycles after each accepted sample
//   out_data       N_CH packed signed codes, channel c at [c*OUT_BW +: OUT_BW]
// -----------------------------------------------------------------------------

// Per-channel MASH core: accumulator chain, carry history and the noise-
// cancelling combiner. The combiner output is combinational; the top
// registers it.
module mash_dsm_lane #(
  parameter int WIDTH  = 16,
  parameter int OUT_BW = 4
) (
  input  logic              aclk,
  input  logic              rst_n,
  input  logic              i_clr,    // synchronous clear (flush)
  input  logic              i_acc,    // sample accepted this cycle
  input  logic [1:0]        i_order,  // 1..3, already clamped
  input  logic [WIDTH-1:0]  i_u,      // offset-binary sample
  input  logic              i_dith,   // dither bit for this channel
  output logic [OUT_BW-1:0] o_y
);

  logic [2:0][WIDTH-1:0] r_acc;
  logic [2:0]            r_c;
  logic [2:0]            r_cd;
  logic [2:0]            r_cdd;

  logic [2:0][WIDTH:0]   w_sum;
  logic [2:0][WIDTH-1:0] w_acc_nx;
  logic [2:0]            w_c_nx;
  logic [WIDTH-1:0]      w_link;

  // Stage k+1 consumes the freshly computed accumulator of stage k in the
  // same cycle. Stages above the active order stay at zero.
  always_comb begin
    w_sum    = '0;
    w_acc_nx = '0;
    w_c_nx   = '0;
    w_link   = i_u;
    for (int k = 0; k < 3; k++) begin
      if (k < int'(i_order)) begin
        w_sum[k]    = {1'b0, r_acc[k]} + {1'b0, w_link}
                    + {{WIDTH{1'b0}}, ((k == int'(i_order) - 1) & i_dith)};
        w_acc_nx[k] = w_sum[k][WIDTH-1:0];
        w_c_nx[k]   = w_sum[k][WIDTH];
        w_link      = w_sum[k][WIDTH-1:0];
      end
    end
  end

  // Carry delay lines advance only with accepted samples, so gaps in ce do
  // not change the code sequence.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_c   <= '0;
      r_cd  <= '0;
      r_cdd <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_c   <= '0;
      r_cd  <= '0;
      r_cdd <= '0;
    end else if (i_acc) begin
      r_acc <= w_acc_nx;
      r_c   <= w_c_nx;
      r_cd  <= r_c;
      r_cdd <= r_cd;
    end
  end

  function automatic logic [OUT_BW-1:0] ext(input logic b);
    return {{(OUT_BW-1){1'b0}}, b};
  endfunction

  // Noise cancellation: y = c1 + (1-z^-1)c2 + (1-z^-1)^2 c3. Two's-complement
  // wrap in OUT_BW bits is exact because the result range always fits.
  always_comb begin
    o_y = ext(r_c[0]);
    if (i_order >= 2'd2) o_y = o_y + ext(r_c[1]) - ext(r_cd[1]);
    if (i_order == 2'd3) o_y = o_y + ext(r_c[2]) - (ext(r_cd[2]) << 1) + ext(r_cdd[2]);
  end

endmodule

module mash_dsm_mc #(
  parameter int          WIDTH     = 16,
  parameter int          N_CH      = 2,
  parameter int          MAX_ORDER = 3,
  parameter int          OUT_BW    = 4,
  parameter int          RST_ORDER = 2,
  parameter logic [22:0] LFSR_SEED = 23'h5A5A5A
) (
  input  logic                   aclk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic [N_CH*WIDTH-1:0]  in_data,
  input  logic                   dither_enable,
  input  logic                   cfg_load,
  input  logic [1:0]             order_sel,
  output logic                   busy,
  output logic [1:0]             order_cur,
  output logic                   out_valid,
  output logic [N_CH*OUT_BW-1:0] out_data
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t                       r_state, w_state_nx;
  logic                         r_cnt, w_cnt_nx;
  logic [1:0]                   r_order;
  logic [1:0]                   w_order_req;
  logic [22:0]                  r_lfsr;
  logic [2:1]                   r_vld_pipe;
  logic [N_CH-1:0][OUT_BW-1:0]  r_out;
  logic                         w_acc;
  logic [N_CH-1:0][WIDTH-1:0]   w_u;
  logic [N_CH-1:0][OUT_BW-1:0]  w_y;

  assign busy      = (r_state == S_FLUSH);
  // cfg_load has priority over a coincident sample strobe.
  assign w_acc     = ce & ~busy & ~cfg_load;
  assign order_cur = r_order;
  assign out_valid = r_vld_pipe[2];
  assign out_data  = r_out;

  always_comb begin
    w_order_req = order_sel;
    if (order_sel == 2'd0)                  w_order_req = 2'd1;
    else if (int'(order_sel) > MAX_ORDER)   w_order_req = 2'(MAX_ORDER);
  end

  // Flush lasts two cycles; a cfg_load during flush restarts the count.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (cfg_load) begin
      w_state_nx = S_FLUSH;
      w_cnt_nx   = 1'b1;
    end else if (r_state == S_FLUSH) begin
      if (r_cnt) w_cnt_nx   = 1'b0;
      else       w_state_nx = S_RUN;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= 1'b0;
      r_order <= 2'(RST_ORDER);
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (cfg_load) r_order <= w_order_req;
    end
  end

  // Fibonacci LFSR x^23 + x^18 + 1; survives flushes, steps per sample.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n)     r_lfsr <= LFSR_SEED;
    else if (w_acc) r_lfsr <= {r_lfsr[21:0], r_lfsr[22] ^ r_lfsr[17]};
  end

  // Output stage: carries land in cycle n+1, the combined code in n+2.
  // Clearing the valid pipe on cfg_load discards samples still in flight.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_out      <= '0;
    end else if (cfg_load) begin
      r_vld_pipe <= '0;
      r_out      <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], w_acc};
      if (r_vld_pipe[1]) r_out <= w_y;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    // Flip the sign bit: signed two's complement -> offset binary.
    assign w_u[c] = in_data[c*WIDTH +: WIDTH] ^ {1'b1, {(WIDTH-1){1'b0}}};

    mash_dsm_lane #(
      .WIDTH  (WIDTH),
      .OUT_BW (OUT_BW)
    ) u_lane (
      .aclk    (aclk),
      .rst_n   (rst_n),
      .i_clr   (cfg_load),
      .i_acc   (w_acc),
      .i_order (r_order),
      .i_u     (w_u[c]),
      .i_dith  (dither_enable & r_lfsr[c]),
      .o_y     (w_y[c])
    );
  end

endmodule

// File: tb/tb_mash_dsm_mc.sv
`timescale 1ns/1ps
// Bench for mash_dsm_mc: a behavioural integer model predicts every code,
// which is queued with its due cycle and compared when out_valid fires.
module tb_mash_dsm_mc;
  localparam int W  = 16;
  localparam int NC = 2;
  localparam int MO = 3;
  localparam int OB = 4;
  localparam int RO = 2;
  localparam logic [22:0] SEED = 23'h5A5A5A;
  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

  logic            aclk = 1'b0;
  logic            rst_n = 1'b1;
  logic            ce = 1'b0;
  logic [NC*W-1:0] in_data = '0;
  logic            dither_enable = 1'b0;
  logic            cfg_load = 1'b0;
  logic [1:0]      order_sel = 2'd0;
  logic            busy;
  logic [1:0]      order_cur;
  logic            out_valid;
  logic [NC*OB-1:0] out_data;

  mash_dsm_mc #(.WIDTH(W), .N_CH(NC), .MAX_ORDER(MO), .OUT_BW(OB),
                .RST_ORDER(RO), .LFSR_SEED(SEED)) dut (
    .aclk(aclk), .rst_n(rst_n), .ce(ce), .in_data(in_data),
    .dither_enable(dither_enable), .cfg_load(cfg_load), .order_sel(order_sel),
    .busy(busy), .order_cur(order_cur), .out_valid(out_valid), .out_data(out_data));

  always #5 aclk = ~aclk;

  typedef struct { logic [NC*OB-1:0] data; int due; int ord; } exp_t;
  exp_t sb_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;

  int m_acc[NC][3], m_c[NC][3], m_cd[NC][3], m_cdd[NC][3];
  int m_order = RO;
  logic [22:0] m_lfsr = SEED;
  bit m_dith = 0;
  int m_cfg_cyc = -100;

  int rx_sum[NC];
  logic [NC*OB-1:0] rx_log[$];
  int rx_cyc[$];
  logic [NC*OB-1:0] ref3[$];
  logic [NC*W-1:0] vec[24];

  function automatic logic [NC*W-1:0] both(input logic [W-1:0] a, input logic [W-1:0] b);
    return {b, a};
  endfunction

  task automatic model_clear();
    for (int ch = 0; ch < NC; ch++)
      for (int k = 0; k < 3; k++) begin
        m_acc[ch][k] = 0; m_c[ch][k] = 0; m_cd[ch][k] = 0; m_cdd[ch][k] = 0;
      end
  endtask

  task automatic model_accept(input logic [NC*W-1:0] d);
    exp_t e;
    int s, lnk, y;
    logic [W-1:0] u;
    e.data = '0;
    for (int ch = 0; ch < NC; ch++) begin
      u = d[ch*W +: W] ^ MSB;
      lnk = int'(u);
      for (int k = 0; k < 3; k++) begin
        s = 0;
        if (k < m_order) begin
          s = m_acc[ch][k] + lnk + ((k == m_order - 1 && m_dith) ? int'(m_lfsr[ch]) : 0);
          m_acc[ch][k] = s % (1 << W);
          lnk = m_acc[ch][k];
        end
        m_cdd[ch][k] = m_cd[ch][k];
        m_cd[ch][k]  = m_c[ch][k];
        m_c[ch][k]   = s >> W;
      end
      y = m_c[ch][0];
      if (m_order >= 2) y += m_c[ch][1] - m_cd[ch][1];
      if (m_order >= 3) y += m_c[ch][2] - 2 * m_cd[ch][2] + m_cdd[ch][2];
      e.data[ch*OB +: OB] = y[OB-1:0];
    end
    e.due = cyc + 2;
    e.ord = m_order;
    sb_q.push_back(e);
    m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
  endtask

  // One clock: scoreboard at the falling edge, then advance past the rising edge.
  task automatic step();
    exp_t e;
    logic signed [OB-1:0] code;
    int lo, hi;
    bit bad;
    @(negedge aclk);
    if (out_valid === 1'b1) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected cyc=%0d got out_data=%h, expected no output", cyc, out_data);
      end else begin
        e = sb_q.pop_front();
        if (out_data !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL sb_code got %h at cyc %0d, expected %h at cyc %0d", out_data, cyc, e.data, e.due);
        end
        rx_log.push_back(out_data);
        rx_cyc.push_back(cyc);
        hi = 1 << (e.ord - 1);
        lo = 1 - hi;
        bad = 0;
        for (int ch = 0; ch < NC; ch++) begin
          code = out_data[ch*OB +: OB];
          rx_sum[ch] += int'(code);
          if (int'(code) < lo || int'(code) > hi) bad = 1;
        end
        n_chk++;
        if (bad) begin
          n_fail++;
          $display("FAIL code_range order %0d got %h, expected codes in %0d..%0d", e.ord, out_data, lo, hi);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      n_chk++; n_fail++;
      $display("FAIL sb_missing cyc=%0d got out_valid=%b, expected code %h", cyc, out_valid, sb_q[0].data);
      void'(sb_q.pop_front());
    end
    @(posedge aclk);
    cyc++;
    #1;
  endtask

  task automatic drive(input bit c, input logic [NC*W-1:0] d, input bit cfg = 0, input logic [1:0] osel = 2'd0);
    ce = c; in_data = d; cfg_load = cfg; order_sel = osel;
    if (cfg) begin
      while (sb_q.size() > 0 && sb_q[$].due > cyc) void'(sb_q.pop_back());
      model_clear();
      m_order = (osel == 2'd0) ? 1 : ((int'(osel) > MO) ? MO : int'(osel));
      m_cfg_cyc = cyc;
    end else if (c && rst_n && !(cyc > m_cfg_cyc && cyc <= m_cfg_cyc + 2)) begin
      model_accept(d);
    end
    step();
    ce = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic clear_rx();
    rx_log.delete(); rx_cyc.delete();
    for (int ch = 0; ch < NC; ch++) rx_sum[ch] = 0;
  endtask

  task automatic set_order(input logic [1:0] osel);
    drive(0, '0, 1, osel);
    drive(0, '0);
    drive(0, '0);
  endtask

  task automatic drain();
    repeat (3) drive(0, '0);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b expected 0", out_valid); end
    n_chk++; if (out_data !== '0)   begin n_fail++; $display("FAIL rst_data got %h expected 0", out_data); end
    n_chk++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy got %b expected 0", busy); end
    n_chk++; if (order_cur !== 2'(RO)) begin n_fail++; $display("FAIL rst_order got %0d expected %0d", order_cur, RO); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_order1();
    int t0, bad;
    logic [OB-1:0] want;
    drive(0, '0, 1, 2'd0);
    n_chk++; if (busy !== 1'b1 || order_cur !== 2'd1) begin n_fail++;
      $display("FAIL cfg0_first got busy=%b order=%0d expected busy=1 order=1", busy, order_cur); end
    drive(0, '0);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cfg0_second got busy=%b expected 1", busy); end
    drive(0, '0);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfg0_done got busy=%b expected 0", busy); end
    clear_rx();
    t0 = cyc;
    repeat (8) drive(1, both(16'h0000, 16'h0000));
    drain();
    n_chk++; if (rx_log.size() != 8 || rx_cyc[0] != t0 + 2) begin n_fail++;
      $display("FAIL o1_latency got %0d codes first at cyc %0d, expected 8 first at cyc %0d",
               rx_log.size(), (rx_cyc.size() > 0) ? rx_cyc[0] : -1, t0 + 2); end
    bad = 0;
    for (int i = 0; i < rx_log.size(); i++) begin
      want = OB'(i % 2);
      if (rx_log[i][OB-1:0] !== want) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL o1_pattern got %0d codes off the 0,1,0,1 pattern, expected 0", bad); end
  endtask

  task automatic test_extremes(input int ord, input int n);
    longint err;
    set_order(2'(ord));
    clear_rx();
    repeat (64) drive(1, both(16'h8000, 16'h8000));
    drain();
    n_chk++; if (rx_log.size() != 64 || rx_sum[0] != 0 || rx_sum[1] != 0) begin n_fail++;
      $display("FAIL min_o%0d got %0d codes sums %0d/%0d, expected 64 codes sums 0/0", ord, rx_log.size(), rx_sum[0], rx_sum[1]); end
    clear_rx();
    repeat (n) drive(1, both(16'h7FFF, 16'h7FFF));
    drain();
    for (int ch = 0; ch < NC; ch++) begin
      err = longint'(rx_sum[ch]) * 65536 - longint'(n) * 65535;
      if (err < 0) err = -err;
      n_chk++; if (err > longint'(1 << (ord - 1)) * 65536) begin n_fail++;
        $display("FAIL max_o%0d_ch%0d got sum %0d, expected %0d*65535/65536 within %0d", ord, ch, rx_sum[ch], n, 1 << (ord - 1)); end
    end
  endtask

  task automatic test_order3_iq();
    longint err;
    int n = 4096;
    int u[NC];
    u[0] = 'h9234; u[1] = 'h6000;
    set_order(2'd3);
    clear_rx();
    repeat (n) drive(1, both(16'h1234, 16'hE000));
    drain();
    for (int ch = 0; ch < NC; ch++) begin
      err = longint'(rx_sum[ch]) * 65536 - longint'(n) * u[ch];
      if (err < 0) err = -err;
      n_chk++; if (err > 4 * 65536) begin n_fail++;
        $display("FAIL iq_ch%0d got sum %0d, expected %0d*%0d/65536 within 4", ch, rx_sum[ch], n, u[ch]); end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int i = 0; i < 24; i++) vec[i] = $urandom;
    set_order(2'd3);
    clear_rx();
    for (int i = 0; i < 24; i++) drive(1, vec[i]);
    drain();
    ref3 = rx_log;
    set_order(2'd3);
    clear_rx();
    for (int i = 0; i < 24; i++) begin
      drive(1, vec[i]);
      repeat (3) drive(0, vec[i]);
    end
    drain();
    bad = 0;
    for (int i = 0; i < 24; i++)
      if (i >= rx_log.size() || i >= ref3.size() || rx_log[i] !== ref3[i]) bad++;
    n_chk++; if (bad != 0 || ref3.size() != 24) begin n_fail++;
      $display("FAIL gapped_seq got %0d differing codes of %0d, expected 0 of 24", bad, ref3.size()); end
  endtask

  task automatic test_cfg_midstream();
    int bad;
    set_order(2'd2);
    clear_rx();
    repeat (10) drive(1, both(16'h3000, 16'hC123));
    drive(1, both(16'h3000, 16'hC123), 1, 2'd3);
    n_chk++; if (busy !== 1'b1 || out_valid !== 1'b0 || order_cur !== 2'd3 || out_data !== '0) begin n_fail++;
      $display("FAIL flush1 got busy=%b vld=%b order=%0d data=%h, expected 1 0 3 0", busy, out_valid, order_cur, out_data); end
    drive(1, both(16'h3000, 16'hC123));
    n_chk++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush2 got busy=%b vld=%b, expected 1 0", busy, out_valid); end
    drive(1, both(16'h3000, 16'hC123));
    n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_after got busy=%b vld=%b, expected 0 0", busy, out_valid); end
    drain();
    // The fresh order-3 sequence must repeat the one recorded after a clean start.
    clear_rx();
    for (int i = 0; i < 24; i++) drive(1, vec[i]);
    drain();
    bad = 0;
    for (int i = 0; i < 24; i++)
      if (i >= rx_log.size() || rx_log[i] !== ref3[i]) bad++;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL fresh_seq got %0d differing codes, expected 0", bad); end
    // Reload during flush restarts the count.
    drive(0, '0, 1, 2'd2);
    drive(0, '0, 1, 2'd0);
    n_chk++; if (busy !== 1'b1 || order_cur !== 2'd1) begin n_fail++;
      $display("FAIL restart1 got busy=%b order=%0d, expected 1 1", busy, order_cur); end
    drive(0, '0);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart2 got busy=%b expected 1", busy); end
    drive(0, '0);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart3 got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    repeat (6) drive(1, both(16'h7FFF, 16'h7FFF));
    n_chk++; if (out_data !== {OB'(1), OB'(1)} || out_valid !== 1'b1) begin n_fail++;
      $display("FAIL pre_rst got data=%h vld=%b, expected %h 1", out_data, out_valid, {OB'(1), OB'(1)}); end
    ce = 1'b1;
    rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || order_cur !== 2'(RO)) begin n_fail++;
      $display("FAIL mid_rst got vld=%b data=%h busy=%b order=%0d, expected 0 0 0 %0d", out_valid, out_data, busy, order_cur, RO); end
    sb_q.delete();
    model_clear();
    m_order = RO; m_lfsr = SEED; m_cfg_cyc = -100;
    drive(0, '0); drive(0, '0);
    rst_n = 1'b1;
    drive(0, '0);
    // Dithered order 2 at mid-scale.
    dither_enable = 1'b1; m_dith = 1;
    clear_rx();
    repeat (4096) drive(1, both(16'h0000, 16'h0000));
    drain();
    for (int ch = 0; ch < NC; ch++) begin
      n_chk++; if (rx_sum[ch] < 2048 - 8 || rx_sum[ch] > 2048 + 8) begin n_fail++;
        $display("FAIL dither_ch%0d got sum %0d, expected 2048 +-8", ch, rx_sum[ch]); end
    end
    dither_enable = 1'b0; m_dith = 0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_order1();
    test_extremes(2, 2048);
    test_extremes(3, 2048);
    test_order3_iq();
    test_back_to_back();
    test_cfg_midstream();
    test_reset_mid();
    n_chk++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d pending codes, expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no completion by cycle %0d, expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
